// File: rtl/alu_exec.sv
// Execution core: drains the instruction FIFO, reads two register-file operands per
// instruction, computes the result and pushes it into the result FIFO.
module alu_exec #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RF_AW  = 4,
    parameter int unsigned MUL_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start_i,
    input  logic              inst_empty_i,
    output logic              inst_rd_en_o,
    input  logic [DATA_W-1:0] inst_dout_i,
    output logic [RF_AW-1:0]  rf_addr_a_o,
    output logic [RF_AW-1:0]  rf_addr_b_o,
    input  logic [DATA_W-1:0] rf_data_a_i,
    input  logic [DATA_W-1:0] rf_data_b_i,
    input  logic              r_full_i,
    output logic              r_wr_en_o,
    output logic [DATA_W-1:0] r_din_o,
    output logic              busy_o,
    output logic              op_done_o,
    output logic              fault_o
);

    localparam int unsigned CntW = $clog2(MUL_W + 1);

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpNot = 4'h1;
    localparam logic [3:0] OpAnd = 4'h2;
    localparam logic [3:0] OpOr  = 4'h3;
    localparam logic [3:0] OpXor = 4'h4;
    localparam logic [3:0] OpAdd = 4'h5;
    localparam logic [3:0] OpSub = 4'h6;
    localparam logic [3:0] OpShl = 4'h7;
    localparam logic [3:0] OpShr = 4'h8;
    localparam logic [3:0] OpAsr = 4'h9;
    localparam logic [3:0] OpMul = 4'hA;

    typedef enum logic [3:0] {
        StIdle, StFetch, StLatch, StExec, StMul, StWrite, StNext, StDone, StFault
    } state_e;

    state_e            state_q;
    logic [15:0]       inst_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] mcand_q;
    logic [MUL_W-1:0]  mplier_q;
    logic [CntW-1:0]   cnt_q;
    logic              inst_rd_en_q;
    logic              op_done_q;
    logic              fault_q;

    logic [3:0]        op;
    logic [3:0]        shamt;
    logic [3:0]        new_op;
    logic [DATA_W-1:0] alu_res;
    logic              unused_inst_hi;

    assign op             = inst_q[15:12];
    assign shamt          = inst_q[3:0];
    assign new_op         = inst_dout_i[15:12];
    assign unused_inst_hi = ^inst_dout_i[DATA_W-1:16];

    always_comb begin
        alu_res = '0;
        case (op)
            OpNot:   alu_res = ~rf_data_a_i;
            OpAnd:   alu_res = rf_data_a_i & rf_data_b_i;
            OpOr:    alu_res = rf_data_a_i | rf_data_b_i;
            OpXor:   alu_res = rf_data_a_i ^ rf_data_b_i;
            OpAdd:   alu_res = rf_data_a_i + rf_data_b_i;
            OpSub:   alu_res = rf_data_a_i - rf_data_b_i;
            OpShl:   alu_res = rf_data_a_i << shamt;
            OpShr:   alu_res = rf_data_a_i >> shamt;
            OpAsr:   alu_res = $unsigned($signed(rf_data_a_i) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            inst_q       <= '0;
            result_q     <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            cnt_q        <= '0;
            inst_rd_en_q <= 1'b0;
            op_done_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            inst_rd_en_q <= 1'b0;
            op_done_q    <= 1'b0;
            fault_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (inst_empty_i) begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                        end else begin
                            state_q      <= StFetch;
                            inst_rd_en_q <= 1'b1;
                        end
                    end
                end
                StFetch: state_q <= StLatch;
                StLatch: begin
                    inst_q <= inst_dout_i[15:0];
                    cnt_q  <= '0;
                    if (new_op == OpNop) begin
                        state_q <= StNext;
                    end else if (new_op == OpMul) begin
                        state_q <= StMul;
                    end else if (new_op <= OpAsr) begin
                        state_q <= StExec;
                    end else begin
                        state_q <= StFault;
                        fault_q <= 1'b1;
                    end
                end
                StExec: begin
                    result_q <= alu_res;
                    state_q  <= StWrite;
                end
                StMul: begin
                    // Step 0 snapshots the operands; steps 1..MUL_W do one shift-add each.
                    if (cnt_q == '0) begin
                        mcand_q  <= {{(DATA_W-MUL_W){1'b0}}, rf_data_a_i[MUL_W-1:0]};
                        mplier_q <= rf_data_b_i[MUL_W-1:0];
                        result_q <= '0;
                        cnt_q    <= CntW'(1);
                    end else begin
                        if (mplier_q[0]) begin
                            result_q <= result_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        if (cnt_q == CntW'(MUL_W)) begin
                            state_q <= StWrite;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StWrite: begin
                    if (!r_full_i) begin
                        state_q <= StNext;
                    end
                end
                StNext: begin
                    if (inst_empty_i) begin
                        state_q   <= StDone;
                        op_done_q <= 1'b1;
                    end else begin
                        state_q      <= StFetch;
                        inst_rd_en_q <= 1'b1;
                    end
                end
                StDone:  state_q <= StIdle;
                StFault: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // The push must see r_full in the same cycle, so it is decoded from state here.
    assign r_wr_en_o    = (state_q == StWrite) && !r_full_i;
    assign r_din_o      = result_q;
    assign busy_o       = (state_q != StIdle);
    assign inst_rd_en_o = inst_rd_en_q;
    assign op_done_o    = op_done_q;
    assign fault_o      = fault_q;
    assign rf_addr_a_o  = (state_q == StIdle) ? '0 : inst_q[8 +: RF_AW];
    assign rf_addr_b_o  = (state_q == StIdle) ? '0 : inst_q[4 +: RF_AW];

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: models the instruction FIFO and register file, scoreboards every
// result push and checks run latencies for table vectors and multi-cycle corner cases.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        inst_empty = 1'b1;
    logic        inst_rd_en;
    logic [31:0] inst_dout = '0;
    logic [3:0]  rf_addr_a, rf_addr_b;
    logic [31:0] rf_data_a, rf_data_b;
    logic        r_full = 1'b0;
    logic        r_wr_en;
    logic [31:0] r_din;
    logic        busy, op_done, fault;

    logic [31:0] rf [16];
    logic [31:0] ifq [$];
    logic [31:0] expq [$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          full_hi = 0;
    int          wr_lat, done_lat, fault_lat, rd_lat, n_wr, n_rd;

    assign rf_data_a = rf[rf_addr_a];
    assign rf_data_b = rf[rf_addr_b];

    alu_exec dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start),
        .inst_empty_i (inst_empty),
        .inst_rd_en_o (inst_rd_en),
        .inst_dout_i  (inst_dout),
        .rf_addr_a_o  (rf_addr_a),
        .rf_addr_b_o  (rf_addr_b),
        .rf_data_a_i  (rf_data_a),
        .rf_data_b_i  (rf_data_b),
        .r_full_i     (r_full),
        .r_wr_en_o    (r_wr_en),
        .r_din_o      (r_din),
        .busy_o       (busy),
        .op_done_o    (op_done),
        .fault_o      (fault)
    );

    always #5 clk = ~clk;

    // r_full changes just after the rising edge so the whole cycle sees one value.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        r_full = (cyc < full_hi);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // FIFO model and result scoreboard.
    always @(negedge clk) begin
        if (reset_n && r_wr_en) begin
            check("wr_while_full", {31'b0, r_full}, 32'h0);
            check("wr_with_rd", {31'b0, inst_rd_en}, 32'h0);
            n_cmp++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_push: got 0x%08h, expected no push", r_din);
            end else begin
                check("r_din", r_din, expq.pop_front());
            end
        end
        if (reset_n && inst_rd_en) begin
            check("rd_while_empty", {31'b0, inst_empty}, 32'h0);
            if (ifq.size() > 0) inst_dout = ifq.pop_front();
            inst_empty = (ifq.size() == 0);
        end
        if (op_done && fault) begin
            check("done_and_fault", 32'h1, 32'h0);
        end
    end

    task automatic load(input logic [31:0] inst);
        ifq.push_back(inst);
        inst_empty = 1'b0;
    endtask

    // One run: start sampled at cycle 0, latencies recorded relative to it.
    task automatic run(input int hold);
        int k;
        int c;
        wr_lat = -1; done_lat = -1; fault_lat = -1; rd_lat = -1; n_wr = 0; n_rd = 0;
        @(negedge clk);
        start = 1'b1;
        k = cyc;
        if (hold > 0) full_hi = k + 4 + hold;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            c = cyc - k;
            if (r_wr_en) begin
                n_wr++;
                if (wr_lat < 0) wr_lat = c;
            end
            if (inst_rd_en) begin
                n_rd++;
                if (rd_lat < 0) rd_lat = c;
            end
            if (hold > 0 && c == 8) begin
                check("busy_in_full_wait", {31'b0, busy}, 32'h1);
                check("wr_held_while_full", {31'b0, r_wr_en}, 32'h0);
            end
            if (op_done) done_lat = c;
            if (fault) fault_lat = c;
            if (done_lat >= 0 || fault_lat >= 0) break;
        end
        full_hi = 0;
        n_cmp++;
        if (done_lat < 0 && fault_lat < 0) begin
            n_bad++;
            $display("FAIL run_timeout: got no op_done/fault, expected one within 100 cycles");
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] inst;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          wr;
        int          done;
    } vec_t;

    vec_t tv [14];

    initial begin
        tv[0]  = '{32'h5120, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000,  4,  6};
        tv[1]  = '{32'h5120, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000,  4,  6};
        tv[2]  = '{32'h1120, 32'h0F0F_0000, 32'h1234_5678, 32'hF0F0_FFFF,  4,  6};
        tv[3]  = '{32'h2120, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00,  4,  6};
        tv[4]  = '{32'h3120, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0,  4,  6};
        tv[5]  = '{32'h4120, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0,  4,  6};
        tv[6]  = '{32'h6210, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE,  4,  6};
        tv[7]  = '{32'h7124, 32'h8000_0001, 32'h0000_0000, 32'h0000_0010,  4,  6};
        tv[8]  = '{32'h8124, 32'hF000_0000, 32'h0000_0000, 32'h0F00_0000,  4,  6};
        tv[9]  = '{32'h9104, 32'h8000_0000, 32'h0000_0003, 32'hF800_0000,  4,  6};
        tv[10] = '{32'hA340, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 20, 22};
        tv[11] = '{32'hA340, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F, 20, 22};
        tv[12] = '{32'hA340, 32'hABCD_1234, 32'h0002_0002, 32'h0000_2468, 20, 22};
        tv[13] = '{32'h0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, -1,  4};

        for (int i = 0; i < 16; i++) rf[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_rd_en", {31'b0, inst_rd_en}, 32'h0);
        check("rst_wr_en", {31'b0, r_wr_en}, 32'h0);
        check("rst_done", {31'b0, op_done}, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_r_din", r_din, 32'h0);
        check("rst_addr", {24'b0, rf_addr_a, rf_addr_b}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            logic [31:0] w;
            w = tv[i].inst;
            rf[w[11:8]] = tv[i].a;
            rf[w[7:4]]  = tv[i].b;
            if (tv[i].wr >= 0) expq.push_back(tv[i].exp);
            load(w);
            run(0);
            check($sformatf("vec%0d_wr_lat", i), wr_lat, tv[i].wr);
            check($sformatf("vec%0d_done_lat", i), done_lat, tv[i].done);
            check($sformatf("vec%0d_rd_lat", i), rd_lat, 32'd1);
            check($sformatf("vec%0d_sb_empty", i), expq.size(), 32'd0);
        end

        // SUB then ASR in one run; RF[1] is rewritten after the first push.
        rf[1] = 32'h0; rf[2] = 32'h1;
        expq.push_back(32'hFFFF_FFFF);
        expq.push_back(32'hF800_0000);
        load(32'h6120);
        load(32'h9104);
        fork
            run(0);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (r_wr_en) begin
                        rf[1] = 32'h8000_0000;
                        break;
                    end
                end
            end
        join
        check("pair_n_wr", n_wr, 32'd2);
        check("pair_n_rd", n_rd, 32'd2);
        check("pair_done_lat", done_lat, 32'd11);
        check("pair_sb_empty", expq.size(), 32'd0);

        // Result FIFO full for 10 cycles in WRITE
        rf[1] = 32'h5; rf[2] = 32'h7;
        expq.push_back(32'h0000_000C);
        load(32'h5120);
        run(10);
        check("full_wr_lat", wr_lat, 32'd14);
        check("full_n_wr", n_wr, 32'd1);
        check("full_done_lat", done_lat, 32'd16);

        // Illegal opcode after a good instruction; the trailing entry stays queued.
        rf[1] = 32'h1; rf[2] = 32'h2;
        expq.push_back(32'h0000_0003);
        load(32'h5120);
        load(32'hC000);
        load(32'h5120);
        run(0);
        check("ill_n_wr", n_wr, 32'd1);
        check("ill_fault_lat", fault_lat, 32'd8);
        check("ill_no_done", done_lat, 32'hFFFF_FFFF);
        check("ill_left_in_fifo", ifq.size(), 32'd1);
        ifq.delete();
        inst_empty = 1'b1;

        // Reset during MUL at step counter 7 (cycle 10), then an empty-FIFO start.
        begin
            int k;
            int seen;
            seen = 0;
            rf[3] = 32'hFFFF; rf[4] = 32'hFFFF;
            load(32'hA340);
            @(negedge clk);
            start = 1'b1;
            k = cyc;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (r_wr_en || op_done || fault) seen++;
            end
            check("mulrst_cycle", cyc - k, 32'd10);
            reset_n = 1'b0;
            #1;
            check("mulrst_busy", {31'b0, busy}, 32'h0);
            check("mulrst_wr_en", {31'b0, r_wr_en}, 32'h0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (r_wr_en || op_done || fault) seen++;
            end
            check("mulrst_no_pulses", seen, 32'd0);
            reset_n = 1'b1;
            @(negedge clk);
            run(0);
            check("post_rst_fault_lat", fault_lat, 32'd1);
            check("post_rst_no_rd", rd_lat, 32'hFFFF_FFFF);
            check("post_rst_no_wr", n_wr, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, expected finish before 1000000 time units");
        $fatal(1);
    end

endmodule
